// File: rtl/alu_pkg.sv
// Shared opcode definitions and helpers for the pipelined ALU slice.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_ADDC = 3'b010,
    OP_SUBC = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  function automatic logic is_add_op(op_e op);
    return (op == OP_ADD) || (op == OP_ADDC);
  endfunction

endpackage

// File: rtl/pipelined_alu_if.sv
// Operand/result stream bundle for pipelined_alu: valid/ready on both sides.
interface pipelined_alu_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  op_e              op;
  logic             sat_en;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             zero;
  logic             sat;

  modport master (
    output in_valid, op, sat_en, in1, in2, out_ready,
    input  in_ready, out_valid, out, carry, zero, sat
  );

  modport slave (
    input  in_valid, op, sat_en, in1, in2, out_ready,
    output in_ready, out_valid, out, carry, zero, sat
  );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: WIDTH+1 bit arithmetic with optional saturation.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] CONST = WIDTH'('hAA)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  input  logic             sat_en,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             zero,
  output logic             sat
);
  logic [WIDTH:0] wide;

  always_comb begin
    wide = '0;
    case (op)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_ADDC: wide = {1'b0, a} + {1'b0, CONST};
      OP_SUBC: wide = {1'b0, b} - {1'b0, CONST};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      default: wide = {1'b0, a};
    endcase
  end

  // Bit WIDTH is carry for adds and borrow for subtracts; logic ops leave it 0.
  always_comb begin
    carry = wide[WIDTH];
    res   = wide[WIDTH-1:0];
    sat   = 1'b0;
    if (sat_en && carry) begin
      sat = 1'b1;
      res = is_add_op(op) ? '1 : '0;
    end
    zero = (res == '0);
  end
endmodule

// File: rtl/pipelined_alu.sv
// Two-stage elastic ALU pipeline: operand register stage, then result/flag stage.
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] CONST = WIDTH'('hAA)
) (
  input logic            clk,
  input logic            rst,
  pipelined_alu_if.slave bus
);
  logic             s1_valid, s2_valid;
  logic             s1_adv, s2_adv;
  logic [WIDTH-1:0] s1_a, s1_b;
  op_e              s1_op;
  logic             s1_sat;
  logic [WIDTH-1:0] core_res;
  logic             core_carry, core_zero, core_sat;
  logic [WIDTH-1:0] s2_out;
  logic             s2_carry, s2_zero, s2_sat;

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
      s1_sat   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a   <= bus.in1;
        s1_b   <= bus.in2;
        s1_op  <= bus.op;
        s1_sat <= bus.sat_en;
      end
    end
  end

  alu_core #(
    .WIDTH (WIDTH),
    .CONST (CONST)
  ) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .sat_en (s1_sat),
    .res    (core_res),
    .carry  (core_carry),
    .zero   (core_zero),
    .sat    (core_sat)
  );

  // Result registers only load on a real beat so idle outputs keep the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_out   <= '0;
      s2_carry <= 1'b0;
      s2_zero  <= 1'b0;
      s2_sat   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_out   <= core_res;
        s2_carry <= core_carry;
        s2_zero  <= core_zero;
        s2_sat   <= core_sat;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out       = s2_out;
  assign bus.carry     = s2_carry;
  assign bus.zero      = s2_zero;
  assign bus.sat       = s2_sat;
endmodule

// File: tb/tb_pipelined_alu.sv
// Directed bench for pipelined_alu with a queue-based reference scoreboard.
module tb_pipelined_alu;
  import alu_pkg::*;

  typedef struct {
    int unsigned op;
    bit          s;
    int unsigned a;
    int unsigned b;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_alu_if #(.WIDTH(8)) bus ();

  pipelined_alu #(
    .WIDTH (8),
    .CONST (8'hAA)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [10:0] exp_q[$];
  int          acc_log[$];
  int          out_log[$];
  logic [10:0] last_res;
  beat_t       vec[$];
  bit          prev_stall = 0;
  logic [10:0] held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: unsigned integer arithmetic on 8-bit operands, CONST = 170.
  function automatic logic [10:0] model(int unsigned op, bit s, int unsigned a, int unsigned b);
    int r;
    bit c = 0;
    bit st = 0;
    case (op)
      0, 2: begin
        r = int'(a) + ((op == 0) ? int'(b) : 170);
        c = (r > 255);
        if (c && s) begin r = 255; st = 1; end
        else if (c) r = r - 256;
      end
      1, 3: begin
        r = (op == 1) ? int'(a) - int'(b) : int'(b) - 170;
        c = (r < 0);
        if (c && s) begin r = 0; st = 1; end
        else if (c) r = r + 256;
      end
      4: r = int'(a & b);
      5: r = int'(a | b);
      6: r = int'(a ^ b);
      default: r = int'(a);
    endcase
    return {8'(r), c, (r == 0), st};
  endfunction

  always @(negedge clk) begin
    logic [10:0] cur;
    logic [10:0] e;
    cyc++;
    cur = {bus.out, bus.carry, bus.zero, bus.sat};
    if (rst) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", 32'(bus.out_valid), 32'd1);
        chk("stall_data_hold", 32'(cur), 32'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_output", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_result", 32'(cur), 32'(e));
        end
        out_log.push_back(cyc);
        last_res = cur;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(32'(bus.op), bus.sat_en, 32'(bus.in1), 32'(bus.in2)));
        acc_log.push_back(cyc);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      held = cur;
    end
  end

  task automatic put(input beat_t bt);
    bus.in_valid = 1'b1;
    bus.op       = op_e'(bt.op[2:0]);
    bus.sat_en   = bt.s;
    bus.in1      = bt.a[7:0];
    bus.in2      = bt.b[7:0];
  endtask

  task automatic drive_vec();
    int idx = 0;
    int guard = 0;
    logic acc;
    if (vec.size() == 0) return;
    @(posedge clk); #1;
    put(vec[0]);
    while (idx < vec.size() && guard < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        idx++;
        if (idx < vec.size()) put(vec[idx]);
        else bus.in_valid = 1'b0;
      end
    end
    if (idx < vec.size()) begin
      chk("drive_timeout", 32'(idx), 32'(vec.size()));
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_outputs(input int n);
    for (int i = 0; i < 40 && out_log.size() < n; i++) @(negedge clk);
    chk("output_count", 32'(out_log.size()), 32'(n));
  endtask

  task automatic directed(input string name, input int unsigned op, input bit s,
                          input int unsigned a, input int unsigned b, input logic [10:0] exp);
    acc_log.delete();
    out_log.delete();
    vec.delete();
    vec.push_back('{op, s, a, b});
    drive_vec();
    wait_outputs(1);
    if (out_log.size() >= 1 && acc_log.size() >= 1) begin
      chk({name, "_latency"}, 32'(out_log[0] - acc_log[0]), 32'd2);
      chk(name, 32'(last_res), 32'(exp));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = OP_ADD;
    bus.sat_en    = 1'b0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_flags", 32'({bus.out, bus.carry, bus.zero, bus.sat}), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

    directed("add_wrap",   0, 0, 8'hF0, 8'h20, {8'h10, 1'b1, 1'b0, 1'b0});
    directed("add_sat",    0, 1, 8'hF0, 8'h20, {8'hFF, 1'b1, 1'b0, 1'b1});
    directed("sub_wrap",   1, 0, 8'h10, 8'h20, {8'hF0, 1'b1, 1'b0, 1'b0});
    directed("sub_sat",    1, 1, 8'h10, 8'h20, {8'h00, 1'b1, 1'b1, 1'b1});
    directed("addc",       2, 0, 8'h01, 8'h00, {8'hAB, 1'b0, 1'b0, 1'b0});
    directed("addc_edge",  2, 0, 8'h56, 8'h00, {8'h00, 1'b1, 1'b1, 1'b0});
    directed("subc_zero",  3, 1, 8'h00, 8'hAA, {8'h00, 1'b0, 1'b1, 1'b0});
    directed("xor",        6, 0, 8'hFF, 8'h0F, {8'hF0, 1'b0, 1'b0, 1'b0});
    directed("and_nosat",  4, 1, 8'hF0, 8'h0F, {8'h00, 1'b0, 1'b1, 1'b0});

    // Backpressure: consumer stalled, four beats offered.
    acc_log.delete();
    out_log.delete();
    vec.delete();
    for (int i = 0; i < 4; i++) vec.push_back('{i % 8, i[0], 32'(8'h31 * (i + 1)), 32'(8'h47 + i)});
    bus.out_ready = 1'b0;
    fork
      drive_vec();
      begin
        repeat (6) @(negedge clk);
        chk("bp_accepted", 32'(acc_log.size()), 32'd2);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_no_output", 32'(out_log.size()), 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_outputs(4);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Full throughput: 16 back-to-back beats.
    acc_log.delete();
    out_log.delete();
    vec.delete();
    for (int i = 0; i < 16; i++) vec.push_back('{i % 8, i[1], 32'((i * 37) % 256), 32'((i * 29 + 3) % 256)});
    drive_vec();
    wait_outputs(16);
    if (out_log.size() == 16 && acc_log.size() == 16) begin
      for (int j = 0; j < 16; j++) chk("tput_cycle", 32'(out_log[j]), 32'(acc_log[0] + 2 + j));
    end

    // Reset with two beats in flight.
    bus.out_ready = 1'b0;
    acc_log.delete();
    out_log.delete();
    vec.delete();
    vec.push_back('{0, 0, 8'h12, 8'h34});
    vec.push_back('{5, 0, 8'h0F, 8'hF0});
    drive_vec();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_outputs", 32'({bus.out, bus.carry, bus.zero, bus.sat}), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    out_log.delete();
    repeat (5) @(negedge clk);
    chk("midrst_no_ghost", 32'(out_log.size()), 32'd0);
    directed("post_rst_pass", 7, 1, 8'h5A, 8'hC3, {8'h5A, 1'b0, 1'b0, 1'b0});

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipelined_alu.md
Name: pipelined_alu

Overview:
Parametrised successor to the team's registered two-operand ALU. It is a two-stage elastic pipeline:
- stage 1 registers operands, opcode and saturate mode;
- stage 2 registers the result and status flags.
- A valid/ready handshake on both sides provides full throughput and lossless backpressure.

The block sits between an operand source (register file or stream) and a consumer that may stall.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CONST, 8'hAA (WIDTH bits), immediate used by ADDC/SUBC ops

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand beat offered
in_ready  output  1  block accepts beat this cycle
op  input  3  operation select (see Behaviour)
sat_en  input  1  saturating arithmetic for ADD/SUB/ADDC/SUBC
in1  input  WIDTH  operand A
in2  input  WIDTH  operand B
out_valid  output  1  result beat offered
out_ready  input  1  consumer accepts result
out  output  WIDTH  result
carry  output  1  carry-out (add ops) / borrow (sub ops); 0 for logic ops
zero  output  1  out == 0
sat  output  1  result was clamped (only when sat_en=1)

Behaviour:
Reset and interface rules:
- Interface decision: one clock (clk); reset rst is synchronous and active-high.
- On rst: s1_valid=0, s2_valid=0, out_valid=0, out=0, carry=0, zero=0, sat=0.
- On rst, in_ready=1 from the cycle after reset deasserts; all stage data registers clear to 0.
- Reset mid-operation discards every in-flight beat. No output beat appears for beats accepted before reset.

Handshake and pipeline:
- Transfer occurs on a cycle where valid && ready. While out_valid=1 and out_ready=0, out, carry, zero and sat hold stable.
- s2_adv = !s2_valid || out_ready.
- s1_adv = !s1_valid || s2_adv.
- in_ready = s1_adv. This is combinational from out_ready; no combinational path from in_valid to in_ready.
- Stage 1 on s1_adv: s1_valid <= in_valid && in_ready; capture in1, in2, op, sat_en when accepting.
- Stage 2 on s2_adv: s2_valid <= s1_valid; capture the alu_core result of the stage-1 registers.
- Latency is 2 cycles from accept to out_valid with no stalls. Throughput is 1 beat/cycle.
- Capacity is 2 beats. With out_ready=0, in_ready drops after 2 beats are accepted.
- Simultaneous out-accept and in-accept on a full pipe is allowed: no bubble, no loss, order preserved.

Opcodes, all math unsigned, WIDTH bits, computed at WIDTH+1 internally:
- 000 ADD: A+B
- 001 SUB: A-B
- 010 ADDC: A+CONST
- 011 SUBC: B-CONST
- 100 AND
- 101 OR
- 110 XOR
- 111 PASS: out=A

Arithmetic, flag and edge rules:
- carry = bit WIDTH of the add result, or borrow (A<B or B<CONST) for subtract.
- sat_en=0: result wraps modulo 2^WIDTH; sat=0.
- sat_en=1 and carry=1 on an add op: out = all-ones, sat=1.
- sat_en=1 and borrow=1 on a sub op: out = 0, sat=1.
- sat_en has no effect on ops 100-111.
- zero is computed on the final, post-saturation out.
- Flags are registered with out in stage 2.

Decomposition:
- Package alu_pkg holds:
  - op_e enum (3-bit: OP_ADD, OP_SUB, OP_ADDC, OP_SUBC, OP_AND, OP_OR, OP_XOR, OP_PASS);
  - a result struct {out, carry, zero, sat} parametrised by width, or localparams if structs are not used.
- One sub-module, alu_core: purely combinational datapath (operands, op, sat_en -> result and flags). The top level holds only the pipeline registers and handshake logic.

Test Plan:
All scenarios use WIDTH=8, CONST=0xAA.
- ADD 0xF0+0x20, sat_en=0 -> out=0x10, carry=1, sat=0, out_valid exactly 2 cycles after accept. Same with sat_en=1 -> out=0xFF, carry=1, sat=1.
- SUB 0x10-0x20: sat_en=0 -> out=0xF0, carry=1. sat_en=1 -> out=0x00, zero=1, sat=1.
- ADDC A=0x01 -> out=0xAB, carry=0. SUBC B=0xAA -> out=0x00, zero=1, carry=0. XOR 0xFF^0x0F -> 0xF0, carry=0.
- Backpressure: stream 4 beats with out_ready=0 -> exactly 2 accepted and in_ready=0. Release out_ready -> all 4 results emerge in order, outputs stable while stalled, none dropped or duplicated.
- Full throughput: 16 back-to-back beats with out_ready=1 -> 16 results on 16 consecutive cycles starting 2 cycles after the first accept.
- Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 and all outputs 0 the next cycle. Those beats never appear. A beat offered right after reset returns normally.
